lrn_square_sum: RTL and testbench
=================================

Name: lrn_square_sum

Overview:
- Upstream feeder of the LRN normalization stage.
- Consumes a channel-ordered stream of NUM_PE-lane activation vectors, one vector per channel.
- Per lane, computes the sum of squares over a sliding window of LRN_SIZE channels centred on each channel, with zero padding at both ends.
- Emits per-lane square_sum plus the matching centre activation (lrn_center) as a one-cycle enable pulse, the exact shape the normalization stage pushes into its FIFOs.

Parameters:
- OP_WIDTH, 16, per-lane operand width (signed two's complement in, unsigned out).
- NUM_PE, 4, lanes per vector.
- DATA_WIDTH, OP_WIDTH*NUM_PE, packed vector width; lane i occupies bits [i*OP_WIDTH +: OP_WIDTH].
- LRN_SIZE, 5, window size in channels; must be odd and >= 3; HALF = LRN_SIZE/2.
- FRAC_BITS, 8, fixed-point fraction bits; square is right-shifted by FRAC_BITS.
- CH_WIDTH, 10, width of the channel count.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begins a pass; sampled only in IDLE.
- num_channels  in  CH_WIDTH  channels in the pass; captured on accepted start.
- in_valid  in  1  data_in valid.
- in_ready  out  1  block accepts data_in this cycle.
- data_in  in  DATA_WIDTH  activation vector for the next channel.
- square_sum  out  DATA_WIDTH  per-lane windowed sum of squares.
- lrn_center  out  DATA_WIDTH  per-lane centre activation, aligned with square_sum.
- out_valid  out  1  one-cycle pulse; drives the normalization enable.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse coincident with the last out_valid.

Behaviour:
- Reset (async, active-low): state=IDLE; all window/accumulator/counter registers cleared; square_sum=0, lrn_center=0; out_valid, in_ready, busy, done all 0.
- States:
  - IDLE: start=1 and num_channels!=0 -> LOAD. Captures num_channels; clears window, sums, in_cnt and tick_cnt. start with num_channels==0 is ignored.
  - LOAD: in_ready = (in_cnt < N). A tick occurs on in_valid & in_ready and shifts data_in into the window. When the accepted input makes in_cnt==N -> DRAIN.
  - DRAIN: one tick every cycle, shifting in a zero vector. After tick_cnt reaches N+HALF -> IDLE.
- Tick rule: the tick_cnt-th tick (0-based) produces an output iff tick_cnt >= HALF. This gives exactly N outputs, for channels 0..N-1 in order. N <= HALF is legal.
- Per-lane arithmetic:
  - sq = (x*x) >> FRAC_BITS.
  - sq is clipped or truncated to OP_WIDTH per the optional feature.
  - Running sum in SUM_W = OP_WIDTH + clog2(LRN_SIZE) bits: sum_next = sum + sq_new - sq_oldest. Exact, never saturates internally.
  - Output sum is clipped or truncated to OP_WIDTH.
- Window storage: LRN_SIZE squares plus a raw delay line. lrn_center = raw input from HALF ticks earlier (zero pad never appears as a centre).
- Latency: outputs are registered; out_valid rises the cycle after the producing tick.
- In DRAIN, in_ready=0 and in_valid is ignored.
- start while busy is ignored. Gaps in in_valid stall the window; no output is emitted on idle cycles.
- No downstream backpressure: out_valid is unconditional.
- reset asserted mid-pass aborts immediately; no further outputs.

Optional Feature:
- LRN_SQSUM_SAT_EN defined: sq and the output sum saturate to all-ones (2^OP_WIDTH-1) on overflow.
- Not defined: both keep only their low OP_WIDTH bits (wrap).

Decomposition:
- Package lrn_pkg holds:
  - state encoding (IDLE=0, LOAD=1, DRAIN=2);
  - clog2 constant function;
  - SUM_W derivation;
  - the saturate/truncate helper function.
- One natural sub-module, lrn_sqsum_lane:
  - per-lane square, window shift, running sum and centre delay;
  - instantiated NUM_PE times;
  - shares tick, clear and emit controls from the top-level FSM.

Test Plan:
- All parameters default; N=8; every lane 256 (1.0); in_valid held high -> 8 pulses with square_sum lanes 768,1024,1280,1280,1280,1280,1024,768; lrn_center 256 each; done on the 8th pulse; busy drops the next cycle.
- N=1, lanes 512 -> single pulse, square_sum=1024, lrn_center=512. Then N=2, lanes -256 -> two pulses, each square_sum=512.
- Lanes 0x7FFF, N=5 -> with LRN_SQSUM_SAT_EN every square_sum lane = 65535; without it every sq is 0xFF00, so the wrapped sums are 0xFD00, 0xFC00, 0xFB00, 0xFC00, 0xFD00.
- N=8 with in_valid toggling every other cycle -> values identical to scenario 1; no out_valid in cycles without a tick; in_ready=0 during DRAIN.
- Reset asserted after the 3rd output of an N=8 pass -> all outputs 0 immediately. A subsequent start with N=4 yields a clean 4-output pass. start with N=0 stays IDLE.

Source files
------------

// File: rtl/lrn_pkg.sv
// Shared definitions for the LRN square-sum feeder: FSM state encoding,
// width helpers and the overflow policy applied to squares and sums.
// Optional feature macro: LRN_SQSUM_SAT_EN (saturate instead of wrap).
package lrn_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

`ifdef LRN_SQSUM_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Running-sum width: wide enough for LRN_SIZE full-scale squares.
  function automatic int sum_width(input int op_width, input int lrn_size);
    return op_width + clog2(lrn_size);
  endfunction

  // Reduce an unsigned value to w bits: all-ones on overflow when
  // saturation is enabled, otherwise keep the low w bits.
  function automatic logic [63:0] fit_width(input logic [63:0] value, input int w);
    logic [63:0] mask;
    logic [63:0] result;
    mask = (64'd1 << w) - 64'd1;
    if (SAT_EN && ((value & ~mask) != 64'd0)) result = mask;
    else result = value & mask;
    return result;
  endfunction

endpackage

// File: rtl/lrn_square_sum_if.sv
// Control, input stream and result signals of the LRN square-sum feeder.
// The master side starts passes and feeds vectors; the slave is the block.
interface lrn_square_sum_if #(
  parameter int DATA_WIDTH = 64,
  parameter int CH_WIDTH   = 10
);
  logic                  start;
  logic [CH_WIDTH-1:0]   num_channels;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] square_sum;
  logic [DATA_WIDTH-1:0] lrn_center;
  logic                  out_valid;
  logic                  busy;
  logic                  done;

  modport master (
    output start, num_channels, in_valid, data_in,
    input  in_ready, square_sum, lrn_center, out_valid, busy, done
  );

  modport slave (
    input  start, num_channels, in_valid, data_in,
    output in_ready, square_sum, lrn_center, out_valid, busy, done
  );
endinterface

// File: rtl/lrn_sqsum_lane.sv
// One lane of the LRN square-sum: squares the incoming activation, keeps
// the last LRN_SIZE squares plus a HALF-deep raw delay line, and maintains
// an exact running window sum. Results register only on emit ticks.
module lrn_sqsum_lane
  import lrn_pkg::*;
#(
  parameter int OP_WIDTH  = 16,
  parameter int LRN_SIZE  = 5,
  parameter int FRAC_BITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic                tick,
  input  logic                emit,
  input  logic [OP_WIDTH-1:0] x,
  output logic [OP_WIDTH-1:0] square_sum,
  output logic [OP_WIDTH-1:0] lrn_center
);
  localparam int HALF   = LRN_SIZE / 2;
  localparam int SUM_W  = sum_width(OP_WIDTH, LRN_SIZE);
  localparam int PROD_W = 2 * OP_WIDTH;

  logic signed [PROD_W-1:0] prod;
  logic [PROD_W-1:0]        prod_shift;
  logic [OP_WIDTH-1:0]      sq_new;
  logic [SUM_W-1:0]         sum_next;

  logic [OP_WIDTH-1:0] sq_win_reg  [LRN_SIZE];
  logic [OP_WIDTH-1:0] raw_win_reg [HALF];
  logic [SUM_W-1:0]    sum_reg;
  logic [OP_WIDTH-1:0] square_sum_reg;
  logic [OP_WIDTH-1:0] lrn_center_reg;

  // Square is always non-negative, so the shift can be done unsigned.
  assign prod       = PROD_W'(signed'(x)) * PROD_W'(signed'(x));
  assign prod_shift = unsigned'(prod) >> FRAC_BITS;
  assign sq_new     = OP_WIDTH'(fit_width(64'(prod_shift), OP_WIDTH));
  // The oldest square is always part of sum_reg, so this never underflows.
  assign sum_next   = sum_reg + SUM_W'(sq_new) - SUM_W'(sq_win_reg[LRN_SIZE-1]);

  // Window shift, running sum and result capture on each tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < LRN_SIZE; i++) sq_win_reg[i] <= '0;
      for (int i = 0; i < HALF; i++) raw_win_reg[i] <= '0;
      sum_reg        <= '0;
      square_sum_reg <= '0;
      lrn_center_reg <= '0;
    end else if (clear) begin
      for (int i = 0; i < LRN_SIZE; i++) sq_win_reg[i] <= '0;
      for (int i = 0; i < HALF; i++) raw_win_reg[i] <= '0;
      sum_reg <= '0;
    end else if (tick) begin
      sq_win_reg[0] <= sq_new;
      for (int i = 1; i < LRN_SIZE; i++) sq_win_reg[i] <= sq_win_reg[i-1];
      raw_win_reg[0] <= x;
      for (int i = 1; i < HALF; i++) raw_win_reg[i] <= raw_win_reg[i-1];
      sum_reg <= sum_next;
      if (emit) begin
        square_sum_reg <= OP_WIDTH'(fit_width(64'(sum_next), OP_WIDTH));
        lrn_center_reg <= raw_win_reg[HALF-1];
      end
    end
  end

  assign square_sum = square_sum_reg;
  assign lrn_center = lrn_center_reg;
endmodule

// File: rtl/lrn_square_sum.sv
// LRN square-sum feeder: streams NUM_PE-lane channel vectors through a
// centred LRN_SIZE-channel window (zero padded at both ends) and emits the
// per-lane sum of squares with its centre activation as a one-cycle pulse.
// Optional feature macro: LRN_SQSUM_SAT_EN (see lrn_pkg).
module lrn_square_sum
  import lrn_pkg::*;
#(
  parameter int OP_WIDTH   = 16,
  parameter int NUM_PE     = 4,
  parameter int DATA_WIDTH = OP_WIDTH * NUM_PE,
  parameter int LRN_SIZE   = 5,
  parameter int FRAC_BITS  = 8,
  parameter int CH_WIDTH   = 10
) (
  input logic             clk,
  input logic             reset,
  lrn_square_sum_if.slave bus
);
  localparam int HALF = LRN_SIZE / 2;
  localparam logic [CH_WIDTH:0]   HALF_C   = (CH_WIDTH+1)'(HALF);
  localparam logic [CH_WIDTH:0]   TICK_ONE = (CH_WIDTH+1)'(1);
  localparam logic [CH_WIDTH-1:0] CNT_ONE  = CH_WIDTH'(1);

  state_t              state_reg, state_next;
  logic [CH_WIDTH-1:0] n_reg;
  logic [CH_WIDTH-1:0] in_cnt_reg;
  logic [CH_WIDTH:0]   tick_cnt_reg;
  logic                out_valid_reg;
  logic                done_reg;

  logic              clear;
  logic              tick;
  logic              emit;
  logic              last_tick;
  logic              in_ready;
  logic [CH_WIDTH:0] last_idx;

  logic [DATA_WIDTH-1:0] sum_bus;
  logic [DATA_WIDTH-1:0] center_bus;

  // Index of the final tick of a pass: N real channels plus HALF zero pads.
  assign last_idx  = {1'b0, n_reg} + HALF_C - TICK_ONE;
  assign last_tick = (tick_cnt_reg == last_idx);
  assign emit      = tick && (tick_cnt_reg >= HALF_C);

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next state plus tick/clear/ready decode.
  always_comb begin
    state_next = state_reg;
    clear      = 1'b0;
    tick       = 1'b0;
    in_ready   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start && (bus.num_channels != '0)) begin
          clear      = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        in_ready = (in_cnt_reg < n_reg);
        tick     = bus.in_valid && in_ready;
        if (tick && ((in_cnt_reg + CNT_ONE) == n_reg)) state_next = DRAIN;
      end
      DRAIN: begin
        tick = 1'b1;
        if (last_tick) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Channel count capture and input/tick counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_reg        <= '0;
      in_cnt_reg   <= '0;
      tick_cnt_reg <= '0;
    end else if (clear) begin
      n_reg        <= bus.num_channels;
      in_cnt_reg   <= '0;
      tick_cnt_reg <= '0;
    end else if (tick) begin
      tick_cnt_reg <= tick_cnt_reg + TICK_ONE;
      if (state_reg == LOAD) in_cnt_reg <= in_cnt_reg + CNT_ONE;
    end
  end

  // Output strobes, one cycle after the producing tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      out_valid_reg <= emit;
      done_reg      <= emit && last_tick;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_PE; gi++) begin : g_lane
      logic [OP_WIDTH-1:0] lane_x;
      // Zero vectors pad the tail of the window while draining.
      assign lane_x = (state_reg == LOAD) ? bus.data_in[gi*OP_WIDTH +: OP_WIDTH] : '0;

      lrn_sqsum_lane #(
        .OP_WIDTH (OP_WIDTH),
        .LRN_SIZE (LRN_SIZE),
        .FRAC_BITS(FRAC_BITS)
      ) u_lane (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .tick      (tick),
        .emit      (emit),
        .x         (lane_x),
        .square_sum(sum_bus[gi*OP_WIDTH +: OP_WIDTH]),
        .lrn_center(center_bus[gi*OP_WIDTH +: OP_WIDTH])
      );
    end
  endgenerate

  assign bus.in_ready   = in_ready;
  assign bus.square_sum = sum_bus;
  assign bus.lrn_center = center_bus;
  assign bus.out_valid  = out_valid_reg;
  assign bus.done       = done_reg;
  assign bus.busy       = (state_reg != IDLE);
endmodule

// File: tb/tb_lrn_square_sum.sv
// Testbench for lrn_square_sum: table of directed passes with known
// results, random passes checked against a windowed-sum reference model,
// plus reset-abort and zero-channel sequences.
module tb_lrn_square_sum;
  localparam int OPW  = 16;
  localparam int NPE  = 4;
  localparam int DW   = OPW * NPE;
  localparam int CHW  = 10;
  localparam int LSZ  = 5;
  localparam int HALF = LSZ / 2;
  localparam int FRAC = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  lrn_square_sum_if #(.DATA_WIDTH(DW), .CH_WIDTH(CHW)) bus();

  lrn_square_sum #(
    .OP_WIDTH(OPW), .NUM_PE(NPE), .DATA_WIDTH(DW),
    .LRN_SIZE(LSZ), .FRAC_BITS(FRAC), .CH_WIDTH(CHW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  int n_total = 0;
  int n_pass  = 0;

  logic [DW-1:0] stim    [64];
  logic [DW-1:0] exp_sum [64];
  logic [DW-1:0] exp_ctr [64];

  typedef struct {
    int          n;
    logic [15:0] lane;
    int          mode;
    logic [15:0] sums [8];
    logic [15:0] ctr;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Overflow policy of the block, applied to a non-negative value.
  function automatic longint fitw(input longint v);
`ifdef LRN_SQSUM_SAT_EN
    return (v > 65535) ? 65535 : v;
`else
    return v & 65535;
`endif
  endfunction

  // Reference: for every channel, sum the squares of the channels within
  // HALF of it that exist (missing ones count as zero).
  function automatic void model(input int n);
    for (int c = 0; c < n; c++) begin
      for (int l = 0; l < NPE; l++) begin
        longint s = 0;
        for (int d = -HALF; d <= HALF; d++) begin
          int k = c + d;
          if (k >= 0 && k < n) begin
            logic signed [15:0] xv = stim[k][l*OPW +: OPW];
            longint p = longint'(xv) * longint'(xv);
            s += fitw(p >>> FRAC);
          end
        end
        exp_sum[c][l*OPW +: OPW] = 16'(fitw(s));
      end
      exp_ctr[c] = stim[c];
    end
  endfunction

  // One full pass: start, feed n vectors (mode 0 continuous, 1 every other
  // cycle, 2 random gaps), collect and compare every output pulse.
  task automatic run_pass(input int n, input int mode);
    int idx, guard, cnt, cyc;
    logic acc;
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_channels = CHW'(n);
    @(negedge clk);
    bus.start = 1'b0;
    fork
      begin
        idx = 0;
        guard = 0;
        while (idx < n && guard < 4 * n + 50) begin
          if (mode == 0) bus.in_valid = 1'b1;
          else if (mode == 1) bus.in_valid = ((guard % 2) == 0);
          else bus.in_valid = 1'($urandom_range(0, 1));
          bus.data_in = stim[idx];
          acc = bus.in_valid && bus.in_ready;
          @(negedge clk);
          if (acc) idx++;
          guard++;
        end
        check("feed_count", 64'(idx), 64'(n));
        bus.in_valid = 1'b1;
        bus.data_in = {$urandom, $urandom};
        for (int k = 0; k < HALF + 1 && bus.busy; k++) begin
          check("in_ready_drain", 64'(bus.in_ready), 64'd0);
          @(negedge clk);
        end
        bus.in_valid = 1'b0;
      end
      begin
        cnt = 0;
        cyc = 0;
        while (cnt < n && cyc < 4 * n + 60) begin
          @(negedge clk);
          cyc++;
          if (bus.out_valid) begin
            check($sformatf("sum[%0d]", cnt), 64'(bus.square_sum), 64'(exp_sum[cnt]));
            check($sformatf("ctr[%0d]", cnt), 64'(bus.lrn_center), 64'(exp_ctr[cnt]));
            check($sformatf("done[%0d]", cnt), 64'(bus.done), 64'(cnt == n - 1));
            cnt++;
          end
        end
        check("out_count", 64'(cnt), 64'(n));
        @(negedge clk);
        check("busy_after", 64'(bus.busy), 64'd0);
        check("no_extra_valid", 64'(bus.out_valid), 64'd0);
      end
    join
    $display("pass n=%0d mode=%0d complete", n, mode);
  endtask

  initial begin
    int cnt, cyc, n;

    tbl[0].n = 8; tbl[0].lane = 16'd256; tbl[0].mode = 0; tbl[0].ctr = 16'd256;
    tbl[0].sums = '{16'd768, 16'd1024, 16'd1280, 16'd1280, 16'd1280, 16'd1280, 16'd1024, 16'd768};
    tbl[1].n = 1; tbl[1].lane = 16'd512; tbl[1].mode = 0; tbl[1].ctr = 16'd512;
    tbl[1].sums = '{16'd1024, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    tbl[2].n = 2; tbl[2].lane = 16'hFF00; tbl[2].mode = 0; tbl[2].ctr = 16'hFF00;
    tbl[2].sums = '{16'd512, 16'd512, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    tbl[3].n = 5; tbl[3].lane = 16'h7FFF; tbl[3].mode = 0; tbl[3].ctr = 16'h7FFF;
`ifdef LRN_SQSUM_SAT_EN
    tbl[3].sums = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0, 16'd0, 16'd0};
`else
    tbl[3].sums = '{16'hFD00, 16'hFC00, 16'hFB00, 16'hFC00, 16'hFD00, 16'd0, 16'd0, 16'd0};
`endif
    tbl[4] = tbl[0];
    tbl[4].mode = 1;

    bus.start = 1'b0;
    bus.num_channels = '0;
    bus.in_valid = 1'b0;
    bus.data_in = '0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    check("rst_sum", 64'(bus.square_sum), 64'd0);
    check("rst_ctr", 64'(bus.lrn_center), 64'd0);
    check("rst_valid", 64'(bus.out_valid), 64'd0);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_ready", 64'(bus.in_ready), 64'd0);
    reset = 1'b1;

    // Directed table.
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < tbl[r].n; c++) begin
        stim[c]    = {NPE{tbl[r].lane}};
        exp_sum[c] = {NPE{tbl[r].sums[c]}};
        exp_ctr[c] = {NPE{tbl[r].ctr}};
      end
      run_pass(tbl[r].n, tbl[r].mode);
    end

    // Random passes against the reference model.
    for (int r = 0; r < 6; r++) begin
      n = (r == 0) ? 2 : (r == 1) ? 3 : int'($urandom_range(1, 24));
      for (int c = 0; c < n; c++) stim[c] = {$urandom, $urandom};
      model(n);
      run_pass(n, r % 3);
    end

    // Reset in the middle of a pass.
    for (int c = 0; c < 8; c++) stim[c] = {NPE{16'd256}};
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_channels = CHW'(8);
    @(negedge clk);
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.data_in = stim[0];
    cnt = 0;
    cyc = 0;
    while (cnt < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (bus.out_valid) cnt++;
    end
    check("abort_seen3", 64'(cnt), 64'd3);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("abort_sum", 64'(bus.square_sum), 64'd0);
    check("abort_ctr", 64'(bus.lrn_center), 64'd0);
    check("abort_valid", 64'(bus.out_valid), 64'd0);
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_done", 64'(bus.done), 64'd0);
    check("abort_ready", 64'(bus.in_ready), 64'd0);
    $display("reset abort sequence complete");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int c = 0; c < 4; c++) stim[c] = {$urandom, $urandom};
    model(4);
    run_pass(4, 0);

    // Zero-channel start is ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.num_channels = '0;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("n0_busy", 64'(bus.busy), 64'd0);
      check("n0_valid", 64'(bus.out_valid), 64'd0);
      @(negedge clk);
    end
    $display("zero-channel start sequence complete");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
